// File: rtl/wasm_pkg.sv
// Shared opcodes, FSM states, trap causes and LEB128 sizing helper
// for the WASM stack-machine core.
package wasm_pkg;

    localparam logic [7:0] OP_UNREACH = 8'h00;
    localparam logic [7:0] OP_END     = 8'h0B;
    localparam logic [7:0] OP_CALL    = 8'h10;
    localparam logic [7:0] OP_DROP    = 8'h1A;
    localparam logic [7:0] OP_LGET    = 8'h20;
    localparam logic [7:0] OP_LSET    = 8'h21;
    localparam logic [7:0] OP_I32C    = 8'h41;
    localparam logic [7:0] OP_I64C    = 8'h42;
    localparam logic [7:0] OP_ADD     = 8'h6A;
    localparam logic [7:0] OP_SUB     = 8'h6B;
    localparam logic [7:0] OP_MUL     = 8'h6C;
    localparam logic [7:0] OP_I64ADD  = 8'h7C;

    localparam logic [2:0] TC_NONE      = 3'd0;
    localparam logic [2:0] TC_ILLEGAL   = 3'd1;
    localparam logic [2:0] TC_UNDERFLOW = 3'd2;
    localparam logic [2:0] TC_OVERFLOW  = 3'd3;
    localparam logic [2:0] TC_CALL_OVF  = 3'd4;
    localparam logic [2:0] TC_BAD_LOCAL = 3'd5;
    localparam logic [2:0] TC_BAD_IMM   = 3'd6;
    localparam logic [2:0] TC_UNREACH   = 3'd7;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_IMM,
        ST_EXEC,
        ST_HALT,
        ST_TRAP
    } state_t;

    function automatic int leb_max_bytes(input int w);
        return (w + 6) / 7;
    endfunction

    function automatic logic has_imm(input logic [7:0] op);
        return op inside {OP_CALL, OP_LGET, OP_LSET, OP_I32C, OP_I64C};
    endfunction

endpackage

// File: rtl/wasm_leb128_acc.sv
// LEB128 accumulator: one 7-bit group per valid byte, LSB first,
// with optional sign extension from bit 6 of the final byte.
module wasm_leb128_acc
    import wasm_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic              byte_valid,
    input  logic [7:0]        byte_in,
    input  logic              signed_mode,
    output logic [DATA_W-1:0] value,
    output logic              done,
    output logic              overlong
);

    localparam int MAXB = leb_max_bytes(DATA_W);
    localparam int AW   = MAXB * 7;

    logic [AW-1:0] r_acc;
    logic [3:0]    r_cnt;
    logic [7:0]    w_sh;
    logic [AW-1:0] w_chunk;
    logic [AW-1:0] w_ext;
    logic [AW-1:0] w_full;

    always_comb begin
        w_sh    = 8'(r_cnt) * 8'd7;
        w_chunk = AW'(byte_in[6:0]) << w_sh;
        w_ext   = '0;
        if (signed_mode && byte_in[6])
            w_ext = {AW{1'b1}} << (w_sh + 8'd7);
        w_full  = r_acc | w_chunk | w_ext;
    end

    assign value    = DATA_W'(w_full);
    assign done     = byte_valid && !byte_in[7];
    assign overlong = byte_valid && (r_cnt >= 4'(MAXB));

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            r_acc <= '0;
            r_cnt <= '0;
        end else if (byte_valid) begin
            r_acc <= r_acc | w_chunk;
            r_cnt <= r_cnt + 4'd1;
        end
    end

endmodule

// File: rtl/wasm_stack_core.sv
// WASM stack-machine core: byte fetch over rd_en/ready, LEB128 immediates,
// single-cycle execute on register operand/call stacks with sticky traps.
module wasm_stack_core
    import wasm_pkg::*;
#(
    parameter int DATA_W     = 32,
    parameter int ADDR_W     = 32,
    parameter int OP_DEPTH   = 16,
    parameter int CALL_DEPTH = 8,
    parameter int N_LOCALS   = 8
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          rom_mapped,
    input  logic [ADDR_W-1:0]             first_instr,
    output logic [ADDR_W-1:0]             mem_addr,
    output logic                          mem_rd_en,
    input  logic [7:0]                    mem_data,
    input  logic                          mem_ready,
    output logic [31:0]                   func_idx,
    input  logic [ADDR_W-1:0]             func_addr,
    output logic                          halted,
    output logic                          trap,
    output logic [2:0]                    trap_code,
    output logic [$clog2(OP_DEPTH+1)-1:0] op_depth,
    output logic [DATA_W-1:0]             op_top
);

    localparam int OPW = $clog2(OP_DEPTH);
    localparam int SPW = $clog2(OP_DEPTH + 1);
    localparam int CW  = $clog2(CALL_DEPTH);
    localparam int CSW = $clog2(CALL_DEPTH + 1);
    localparam int LW  = $clog2(N_LOCALS);

    state_t            r_state, w_state_nxt;
    logic [ADDR_W-1:0] r_pc;
    logic              r_req;
    logic [7:0]        r_op;
    logic [DATA_W-1:0] r_imm;
    logic [2:0]        r_tcode;
    logic [DATA_W-1:0] r_ops [OP_DEPTH];
    logic [SPW-1:0]    r_sp;
    logic [ADDR_W-1:0] r_cs [CALL_DEPTH];
    logic [CSW-1:0]    r_csp;
    logic [DATA_W-1:0] r_loc [N_LOCALS];

    logic              w_cap, w_has_imm;
    logic [DATA_W-1:0] w_leb_val;
    logic              w_leb_done, w_leb_ovl;
    logic [OPW-1:0]    w_i1, w_i2, w_ip;
    logic [CW-1:0]     w_ci, w_cp;
    logic [LW-1:0]     w_li;
    logic              w_bad_loc, w_full, w_halt;
    logic [DATA_W-1:0] w_a, w_b, w_res;
    logic [31:0]       w_r32;
    logic [2:0]        w_fault, w_tc_nxt;

    assign w_cap     = r_req && mem_ready;
    assign w_has_imm = has_imm(mem_data) && (DATA_W == 64 || mem_data != OP_I64C);

    wasm_leb128_acc #(.DATA_W(DATA_W)) u_leb (
        .clk         (clk),
        .rst         (rst),
        .clr         (r_state == ST_FETCH),
        .byte_valid  (r_state == ST_IMM && w_cap),
        .byte_in     (mem_data),
        .signed_mode (r_op == OP_I32C || r_op == OP_I64C),
        .value       (w_leb_val),
        .done        (w_leb_done),
        .overlong    (w_leb_ovl)
    );

    assign w_i1      = OPW'(r_sp - SPW'(1));
    assign w_i2      = OPW'(r_sp - SPW'(2));
    assign w_ip      = OPW'(r_sp);
    assign w_ci      = CW'(r_csp - CSW'(1));
    assign w_cp      = CW'(r_csp);
    assign w_li      = LW'(r_imm);
    assign w_bad_loc = r_imm >= DATA_W'(N_LOCALS);
    assign w_full    = r_sp == SPW'(OP_DEPTH);
    assign w_a       = r_ops[w_i2];
    assign w_b       = r_ops[w_i1];

    always_comb begin
        w_r32 = w_a[31:0] + w_b[31:0];
        if (r_op == OP_SUB) w_r32 = w_a[31:0] - w_b[31:0];
        if (r_op == OP_MUL) w_r32 = w_a[31:0] * w_b[31:0];
        w_res = DATA_W'(w_r32);
        if (r_op == OP_I64ADD) w_res = w_a + w_b;
    end

    // Fault check for the op in EXEC; pops are checked before pushes.
    always_comb begin
        w_fault = TC_NONE;
        w_halt  = 1'b0;
        case (r_op)
            OP_I32C:   if (w_full) w_fault = TC_OVERFLOW;
            OP_I64C:   if (DATA_W != 64) w_fault = TC_ILLEGAL;
                       else if (w_full) w_fault = TC_OVERFLOW;
            OP_ADD, OP_SUB, OP_MUL:
                       if (r_sp < SPW'(2)) w_fault = TC_UNDERFLOW;
            OP_I64ADD: if (DATA_W != 64) w_fault = TC_ILLEGAL;
                       else if (r_sp < SPW'(2)) w_fault = TC_UNDERFLOW;
            OP_DROP:   if (r_sp == '0) w_fault = TC_UNDERFLOW;
            OP_LGET:   if (w_bad_loc) w_fault = TC_BAD_LOCAL;
                       else if (w_full) w_fault = TC_OVERFLOW;
            OP_LSET:   if (w_bad_loc) w_fault = TC_BAD_LOCAL;
                       else if (r_sp == '0) w_fault = TC_UNDERFLOW;
            OP_CALL:   if (r_csp == CSW'(CALL_DEPTH)) w_fault = TC_CALL_OVF;
            OP_END:    w_halt = (r_csp == '0);
            OP_UNREACH: w_fault = TC_UNREACH;
            default:   w_fault = TC_ILLEGAL;
        endcase
    end

    always_comb begin
        w_state_nxt = r_state;
        w_tc_nxt    = (r_state == ST_IMM) ? TC_BAD_IMM : w_fault;
        case (r_state)
            ST_IDLE:  if (rom_mapped) w_state_nxt = ST_FETCH;
            ST_FETCH: if (w_cap) w_state_nxt = w_has_imm ? ST_IMM : ST_EXEC;
            ST_IMM:   if (w_cap) begin
                          if (w_leb_ovl) w_state_nxt = ST_TRAP;
                          else if (w_leb_done) w_state_nxt = ST_EXEC;
                      end
            ST_EXEC:  if (w_fault != TC_NONE) w_state_nxt = ST_TRAP;
                      else if (w_halt) w_state_nxt = ST_HALT;
                      else w_state_nxt = ST_FETCH;
            default:  w_state_nxt = r_state;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) r_state <= ST_IDLE;
        else     r_state <= w_state_nxt;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pc    <= '0;
            r_req   <= 1'b0;
            r_op    <= '0;
            r_imm   <= '0;
            r_tcode <= '0;
            r_sp    <= '0;
            r_csp   <= '0;
            for (int i = 0; i < OP_DEPTH; i++)   r_ops[i] <= '0;
            for (int i = 0; i < CALL_DEPTH; i++) r_cs[i]  <= '0;
            for (int i = 0; i < N_LOCALS; i++)   r_loc[i] <= '0;
        end else begin
            case (r_state)
                ST_IDLE: if (rom_mapped) r_pc <= first_instr;
                ST_FETCH, ST_IMM: begin
                    // Request drops on capture, guaranteeing an idle cycle.
                    if (w_cap) begin
                        r_req <= 1'b0;
                        r_pc  <= r_pc + 1'b1;
                        if (r_state == ST_FETCH) r_op <= mem_data;
                        if (r_state == ST_IMM && w_leb_done) r_imm <= w_leb_val;
                    end else if (!r_req) begin
                        r_req <= 1'b1;
                    end
                end
                ST_EXEC: if (w_fault == TC_NONE && !w_halt) begin
                    case (r_op)
                        OP_I32C: begin
                            r_ops[w_ip] <= DATA_W'(r_imm[31:0]);
                            r_sp        <= r_sp + 1'b1;
                        end
                        OP_I64C: begin
                            r_ops[w_ip] <= r_imm;
                            r_sp        <= r_sp + 1'b1;
                        end
                        OP_ADD, OP_SUB, OP_MUL, OP_I64ADD: begin
                            r_ops[w_i2] <= w_res;
                            r_sp        <= r_sp - 1'b1;
                        end
                        OP_DROP: r_sp <= r_sp - 1'b1;
                        OP_LGET: begin
                            r_ops[w_ip] <= r_loc[w_li];
                            r_sp        <= r_sp + 1'b1;
                        end
                        OP_LSET: begin
                            r_loc[w_li] <= w_b;
                            r_sp        <= r_sp - 1'b1;
                        end
                        OP_CALL: begin
                            r_cs[w_cp] <= r_pc;
                            r_csp      <= r_csp + 1'b1;
                            r_pc       <= func_addr;
                        end
                        OP_END: begin
                            r_pc  <= r_cs[w_ci];
                            r_csp <= r_csp - 1'b1;
                        end
                        default: ;
                    endcase
                end
                default: ;
            endcase
            if (w_state_nxt == ST_TRAP && r_state != ST_TRAP)
                r_tcode <= w_tc_nxt;
        end
    end

    assign mem_addr  = r_pc;
    assign mem_rd_en = r_req;
    assign func_idx  = r_imm[31:0];
    assign halted    = (r_state == ST_HALT);
    assign trap      = (r_state == ST_TRAP);
    assign trap_code = r_tcode;
    assign op_depth  = r_sp;
    assign op_top    = (r_sp == '0) ? '0 : w_b;

endmodule
